// File: rtl/acc_pkg.sv
// Shared types for the accelerator memory-side blocks: requester ID type,
// arbiter state encoding and a small width helper.
package acc_pkg;

    localparam int unsigned XmemArbNumReq = 4;

    typedef logic [$clog2(XmemArbNumReq)-1:0] xmem_arb_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits for single-entry structures.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/acc_xmem_arb_id_fifo.sv
// In-order FIFO of requester IDs: one entry per issued memory request, popped
// when the matching memory response is accepted.
module acc_xmem_arb_id_fifo
    import acc_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = clog2_min1(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push is refused while full even when a pop frees an entry this cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/acc_xmem_arbiter.sv
// Round-robin arbiter sharing one XMEM port among NumReq requesters, with
// in-order response routing. Define ACC_XMEM_ARB_ERR_EN to add rsp_err_o.
module acc_xmem_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq-1:0]               req_we_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_be_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    input  logic [NumReq-1:0]               rsp_ready_i,
    output logic [DataWidth-1:0]            rsp_rdata_o,
    output logic                            mem_req_valid_o,
    input  logic                            mem_req_ready_i,
    output logic [AddrWidth-1:0]            mem_req_addr_o,
    output logic [DataWidth-1:0]            mem_req_wdata_o,
    output logic                            mem_req_we_o,
    output logic [DataWidth/8-1:0]          mem_req_be_o,
    input  logic                            mem_rsp_valid_i,
    output logic                            mem_rsp_ready_o,
    input  logic [DataWidth-1:0]            mem_rsp_rdata_i
`ifdef ACC_XMEM_ARB_ERR_EN
    ,
    output logic                            rsp_err_o
`endif
);

    localparam int unsigned IdW = clog2_min1(NumReq);
    localparam int unsigned BeW = DataWidth / 8;

    arb_state_e     state_q, state_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] grant_q, grant_d;
    logic [IdW-1:0] winner, sel_id, head_id;
    logic           winner_found, present;
    logic           fifo_full, fifo_empty, push, pop;
    int unsigned    idx;

    // Rotating priority: first valid requester at or after the RR pointer.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        idx          = 0;
        for (int k = 0; k < int'(NumReq); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!winner_found && req_valid_i[idx]) begin
                winner_found = 1'b1;
                winner       = IdW'(idx);
            end
        end
    end

    // Once a request has been presented without ready, it stays presented.
    assign sel_id  = (state_q == LOCKED) ? grant_q : winner;
    assign present = (state_q == LOCKED) ? req_valid_i[grant_q] : winner_found;

    always_comb begin
        mem_req_valid_o = present && !fifo_full;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = '0;
        mem_req_we_o    = 1'b0;
        mem_req_be_o    = '0;
        req_ready_o     = '0;
        if (present) begin
            mem_req_addr_o  = req_addr_i[int'(sel_id)*AddrWidth +: AddrWidth];
            mem_req_wdata_o = req_wdata_i[int'(sel_id)*DataWidth +: DataWidth];
            mem_req_we_o    = req_we_i[sel_id];
            mem_req_be_o    = req_be_i[int'(sel_id)*BeW +: BeW];
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            req_ready_o[sel_id] = 1'b1;
        end
    end

    assign push = mem_req_valid_o && mem_req_ready_i;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (sel_id == IdW'(NumReq - 1)) ? '0 : sel_id + 1'b1;
            state_d  = IDLE;
        end else if (state_q == IDLE && mem_req_valid_o) begin
            state_d = LOCKED;
            grant_d = winner;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    acc_xmem_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (sel_id),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head_id)
    );

    // With nothing outstanding, responses are spurious: swallowed, never forwarded.
    always_comb begin
        rsp_valid_o     = '0;
        mem_rsp_ready_o = 1'b1;
        rsp_rdata_o     = '0;
        if (!fifo_empty) begin
            rsp_valid_o[head_id] = mem_rsp_valid_i;
            mem_rsp_ready_o      = rsp_ready_i[head_id];
            rsp_rdata_o          = mem_rsp_rdata_i;
        end
    end

    assign pop = mem_rsp_valid_i && mem_rsp_ready_o && !fifo_empty;

`ifdef ACC_XMEM_ARB_ERR_EN
    logic rsp_err_q, rsp_err_d;

    assign rsp_err_d = rsp_err_q || (mem_rsp_valid_i && fifo_empty);
    assign rsp_err_o = rsp_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end
`endif

`ifndef SYNTHESIS
    locked_valid_held: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == LOCKED) |-> req_valid_i[grant_q]
    );
`endif

endmodule
